sprite_line_scanner: RTL and testbench
======================================

Name: sprite_line_scanner

Overview:
- Read-side consumer of the sprite register bank: once per video line, during horizontal blanking, it walks registers 0..20 through the bank's read port.
- Captures the background color from register 0.
- Tests sprite registers 1..20 against the next line and publishes a stable list of up to MAX_ACTIVE visible sprites to the pixel drawing stage.
- Sits between the register bank and the sprite renderer; never writes the bank.

Parameters:
N_SPRITES, 20, number of sprite registers (indices 1..N_SPRITES)
SPRITE_H, 20, sprite height in lines
MAX_ACTIVE, 4, active-list slots per line
SCREEN_W, 640, visible width (used only with the optional feature)
SCREEN_H, 480, visible height (used only with the optional feature)

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
start  in  1  one-cycle pulse at hblank start; ignored unless idle
line  in  10  line to be drawn next; sampled with start
rf_n_reg  out  5  register index driven to bank
rf_written  out  1  tied 0 (bank in read mode)
rf_read_data  in  30  bank read data, valid one edge after rf_n_reg
busy  out  1  high from accepted start until commit
done  out  1  one-cycle pulse on list commit
bg_color  out  9  register 0 bits [8:0], updated at commit
act_valid  out  MAX_ACTIVE  slot valid bits
act_x  out  MAX_ACTIVE*10  per-slot x, slot i at [10i+9:10i]
act_row  out  MAX_ACTIVE*5  per-slot row within sprite (line - y)
act_offset  out  MAX_ACTIVE*10  per-slot memory offset
overflow  out  1  more than MAX_ACTIVE hits on committed line

Behaviour:
- Register word format: x [9:0], y [19:10], offset [29:20].
  - offset==0 means the sprite is disabled.
  - Register 0: background color [8:0].
- Reset (reset_n low at edge): state IDLE.
  - busy, done, overflow, act_valid, rf_n_reg and bg_color all 0.
  - act_x, act_row and act_offset all 0.
  - Working list cleared.
  - Reset mid-scan aborts; the committed list is cleared, not partially updated.
- State IDLE: rf_n_reg=0. On start: latch line, clear working list, go to READ.
- State READ: the edge accepting start is E0.
  - rf_n_reg=k during the cycle after edge E0+k, for k=0..20.
  - After index 20 is issued, go to DRAIN.
- Capture of index k happens at edge E0+k+2 (one-edge bank latency).
  - Index 0 loads working bg.
  - Index k≥1 is a hit iff offset!=0, y ≤ line, and line < y+SPRITE_H.
  - The compare is done in 11-bit unsigned arithmetic with no wrap.
- Hit handling:
  - A hit fills the lowest free working slot with x, row=line-y (5 bits) and offset.
  - A hit with all slots full sets working overflow; lower register index always wins.
- State DRAIN: captures index 20 at E0+22, then goes to COMMIT.
- State COMMIT (edge E0+23):
  - Working list, bg and overflow are copied to the outputs.
  - done=1 for exactly that one cycle; busy falls; return to IDLE.
- Total latency: start to done = 23 edges; outputs stay stable between commits.
- start while busy is ignored, with no queuing.
- start coinciding with reset: reset wins.
- Slots are filled contiguously; act_valid is always of the form 0..01..1.

Optional Feature:
- Macro SPRITE_SCAN_CLIP_EN.
- When defined: a sprite with x ≥ SCREEN_W or y ≥ SCREEN_H is never a hit and never sets overflow.
- When undefined: only the offset/y test applies.

Decomposition:
- Shared package sprite_pkg holds:
  - field LSB/width constants (X_LSB=0, Y_LSB=10, OFF_LSB=20, FIELD_W=10);
  - REG_BG=0, N_SPRITES, SPRITE_H, SCREEN_W, SCREEN_H;
  - the state encoding (IDLE, READ, DRAIN, COMMIT).
- One sub-module, sprite_hit_check: combinational.
  - Inputs: line and the 30-bit word.
  - Outputs: hit and row.
  - Honors SPRITE_SCAN_CLIP_EN.

Test Plan:
- Reset, then start with line=50; bank reg0=9'h1A5 and all sprites with offset=0 → done at E0+23, bg_color=1A5, act_valid=0000, overflow=0.
- reg3: y=40, x=100, offset=7; line=50 → act_valid=0001, act_x[0]=100, act_row[0]=10, act_offset[0]=7.
- Boundary: reg5 y=30, line=49 → hit with row 19; line=50 → no hit; reg6 y=50, line=50 → row 0.
- Six sprites (regs 2,4,7,9,11,15) all covering line 100 → slots hold regs 2,4,7,9 in order; overflow=1.
- Second start pulse at E0+5, and reset_n low at E0+10 → second start ignored; after the reset, all outputs are 0 and no done pulse occurs.
- With SPRITE_SCAN_CLIP_EN: reg1 x=700, y=10, offset=3, line=15 → no hit; without the macro → slot 0 holds x=700.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite line scanner: register word field layout,
// sprite geometry and the scan state encoding.
package sprite_pkg;

    localparam int unsigned X_LSB     = 0;
    localparam int unsigned Y_LSB     = 10;
    localparam int unsigned OFF_LSB   = 20;
    localparam int unsigned FIELD_W   = 10;
    localparam int unsigned WORD_W    = 30;
    localparam int unsigned BG_W      = 9;
    localparam int unsigned IDX_W     = 5;
    localparam int unsigned ROW_W     = 5;

    localparam int unsigned REG_BG    = 0;
    localparam int unsigned N_SPRITES = 20;
    localparam int unsigned SPRITE_H  = 20;
    localparam int unsigned SCREEN_W  = 640;
    localparam int unsigned SCREEN_H  = 480;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        COMMIT
    } scan_state_t;

endpackage

// File: rtl/sprite_hit_check.sv
// Combinational test of one sprite register word against the next line.
// Produces the hit flag and the row within the sprite (line - y).
// Optional macro SPRITE_SCAN_CLIP_EN rejects sprites positioned off screen.
module sprite_hit_check
    import sprite_pkg::*;
(
    input  logic [FIELD_W-1:0] line,
    input  logic [WORD_W-1:0]  word,
    output logic               hit,
    output logic [ROW_W-1:0]   row
);

    localparam logic [FIELD_W:0] SPR_H_W = (FIELD_W+1)'(SPRITE_H);

    logic [FIELD_W-1:0] y;
    logic [FIELD_W-1:0] off;
    logic [FIELD_W:0]   y_w;
    logic [FIELD_W:0]   line_w;
    logic [FIELD_W:0]   y_end;

`ifdef SPRITE_SCAN_CLIP_EN
    localparam logic [FIELD_W:0] CLIP_X = (FIELD_W+1)'(SCREEN_W);
    localparam logic [FIELD_W:0] CLIP_Y = (FIELD_W+1)'(SCREEN_H);
    logic [FIELD_W-1:0] x;
    assign x = word[X_LSB +: FIELD_W];
`else
    logic unused_x;
    assign unused_x = ^word[X_LSB +: FIELD_W];
`endif

    // Vertical coverage test in 11 bits so y+SPRITE_H never wraps
    always_comb begin
        y      = word[Y_LSB +: FIELD_W];
        off    = word[OFF_LSB +: FIELD_W];
        y_w    = {1'b0, y};
        line_w = {1'b0, line};
        y_end  = y_w + SPR_H_W;
        row    = line[ROW_W-1:0] - y[ROW_W-1:0];
        hit    = (off != '0) && (y_w <= line_w) && (line_w < y_end);
`ifdef SPRITE_SCAN_CLIP_EN
        if (({1'b0, x} >= CLIP_X) || (y_w >= CLIP_Y)) begin
            hit = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/sprite_line_scanner.sv
// Per-line sprite scanner: walks the register bank during hblank, captures
// the background colour and builds a list of up to MAX_ACTIVE visible
// sprites for the next line, publishing it atomically on commit.
// Optional macro SPRITE_SCAN_CLIP_EN (handled in sprite_hit_check).
module sprite_line_scanner
    import sprite_pkg::*;
#(
    parameter int unsigned MAX_ACTIVE = 4
)
(
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic [9:0]                    line,
    output logic [4:0]                    rf_n_reg,
    output logic                          rf_written,
    input  logic [29:0]                   rf_read_data,
    output logic                          busy,
    output logic                          done,
    output logic [8:0]                    bg_color,
    output logic [MAX_ACTIVE-1:0]         act_valid,
    output logic [MAX_ACTIVE*10-1:0]      act_x,
    output logic [MAX_ACTIVE*5-1:0]       act_row,
    output logic [MAX_ACTIVE*10-1:0]      act_offset,
    output logic                          overflow
);

    localparam int unsigned      CNT_W    = $clog2(MAX_ACTIVE + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SPRITES);
    localparam logic [IDX_W-1:0] BG_IDX   = IDX_W'(REG_BG);

    scan_state_t state, state_nx;

    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   p1_idx;
    logic               p1_v;
    logic [FIELD_W-1:0] line_q;

    logic                                  hit;
    logic [ROW_W-1:0]                      row;

    logic [MAX_ACTIVE-1:0]                 w_valid;
    logic [MAX_ACTIVE-1:0][FIELD_W-1:0]    w_x;
    logic [MAX_ACTIVE-1:0][ROW_W-1:0]      w_row;
    logic [MAX_ACTIVE-1:0][FIELD_W-1:0]    w_off;
    logic [CNT_W-1:0]                      w_cnt;
    logic [BG_W-1:0]                       w_bg;
    logic                                  w_ovf;

    logic [MAX_ACTIVE-1:0][FIELD_W-1:0]    o_x;
    logic [MAX_ACTIVE-1:0][ROW_W-1:0]      o_row;
    logic [MAX_ACTIVE-1:0][FIELD_W-1:0]    o_off;

    assign act_x      = o_x;
    assign act_row    = o_row;
    assign act_offset = o_off;
    assign rf_written = 1'b0;

    sprite_hit_check u_hit (
        .line (line_q),
        .word (rf_read_data),
        .hit  (hit),
        .row  (row)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = READ;
            READ:    if (idx == LAST_IDX) state_nx = DRAIN;
            DRAIN:   state_nx = COMMIT;
            COMMIT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Bank address and busy flag
    always_comb begin
        rf_n_reg = '0;
        busy     = (state != IDLE);
        if (state == READ) begin
            rf_n_reg = idx;
        end
    end

    // Index walk, one-edge-delayed capture into the working list, and commit.
    // p1_* tracks which index the bank is presenting this cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idx       <= '0;
            p1_idx    <= '0;
            p1_v      <= 1'b0;
            line_q    <= '0;
            w_valid   <= '0;
            w_x       <= '0;
            w_row     <= '0;
            w_off     <= '0;
            w_cnt     <= '0;
            w_bg      <= '0;
            w_ovf     <= 1'b0;
            done      <= 1'b0;
            bg_color  <= '0;
            act_valid <= '0;
            o_x       <= '0;
            o_row     <= '0;
            o_off     <= '0;
            overflow  <= 1'b0;
        end else begin
            done   <= 1'b0;
            p1_v   <= (state == READ);
            p1_idx <= idx;

            if (state == IDLE && start) begin
                line_q  <= line;
                idx     <= '0;
                w_valid <= '0;
                w_x     <= '0;
                w_row   <= '0;
                w_off   <= '0;
                w_cnt   <= '0;
                w_bg    <= '0;
                w_ovf   <= 1'b0;
            end else if (state == READ) begin
                idx <= idx + IDX_W'(1);
            end

            if (p1_v) begin
                if (p1_idx == BG_IDX) begin
                    w_bg <= rf_read_data[BG_W-1:0];
                end else if (hit) begin
                    if (w_cnt < CNT_W'(MAX_ACTIVE)) begin
                        for (int unsigned i = 0; i < MAX_ACTIVE; i++) begin
                            if (w_cnt == CNT_W'(i)) begin
                                w_valid[i] <= 1'b1;
                                w_x[i]     <= rf_read_data[X_LSB +: FIELD_W];
                                w_row[i]   <= row;
                                w_off[i]   <= rf_read_data[OFF_LSB +: FIELD_W];
                            end
                        end
                        w_cnt <= w_cnt + CNT_W'(1);
                    end else begin
                        w_ovf <= 1'b1;
                    end
                end
            end

            if (state == COMMIT) begin
                act_valid <= w_valid;
                o_x       <= w_x;
                o_row     <= w_row;
                o_off     <= w_off;
                bg_color  <= w_bg;
                overflow  <= w_ovf;
                done      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sprite_line_scanner.sv
// Self-checking bench for sprite_line_scanner: a behavioural register bank,
// a table of single-sprite vectors, hand sequences for overflow, ignored
// start, reset abort, and randomized scans against a reference model.
module tb_sprite_line_scanner;
    import sprite_pkg::*;

    localparam int MA = 4;

    logic            clk;
    logic            reset_n;
    logic            start;
    logic [9:0]      line;
    logic [4:0]      rf_n_reg;
    logic            rf_written;
    logic [29:0]     rf_read_data;
    logic            busy;
    logic            done;
    logic [8:0]      bg_color;
    logic [MA-1:0]   act_valid;
    logic [MA*10-1:0] act_x;
    logic [MA*5-1:0]  act_row;
    logic [MA*10-1:0] act_offset;
    logic            overflow;

    sprite_line_scanner #(.MAX_ACTIVE(MA)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .line         (line),
        .rf_n_reg     (rf_n_reg),
        .rf_written   (rf_written),
        .rf_read_data (rf_read_data),
        .busy         (busy),
        .done         (done),
        .bg_color     (bg_color),
        .act_valid    (act_valid),
        .act_x        (act_x),
        .act_row      (act_row),
        .act_offset   (act_offset),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register bank model: one-edge read latency
    logic [29:0] bank [0:20];
    always @(posedge clk) rf_read_data <= bank[rf_n_reg];

    int total  = 0;
    int passed = 0;

    int       exp_x   [MA];
    int       exp_row [MA];
    int       exp_off [MA];
    int       exp_n;
    logic     exp_ovf;
    int       exp_bg;

    typedef struct {
        int       bg;
        int       ln;
        int       k;
        int       x;
        int       y;
        int       off;
        logic [3:0] ev;
        int       ex;
        int       er;
        int       eo;
    } vec_t;

    vec_t vec [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [29:0] mkword(input int x, input int y, input int off);
        logic [9:0] xv, yv, ov;
        xv = x[9:0];
        yv = y[9:0];
        ov = off[9:0];
        return {ov, yv, xv};
    endfunction

    task automatic clear_bank(input int bg);
        logic [8:0] b;
        b = bg[8:0];
        bank[0] = {21'd0, b};
        for (int k = 1; k <= 20; k++) bank[k] = '0;
    endtask

    // Pulse start for one edge and wait for done; checks the 23-edge latency
    task automatic run_scan(input int ln, input string tag);
        int lat;
        @(negedge clk);
        start = 1'b1;
        line  = ln[9:0];
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, " busy"}, {31'd0, busy}, 32'd1);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = c;
                break;
            end
        end
        check({tag, " latency"}, lat, 23);
        @(posedge clk);
        #1;
        check({tag, " done width"}, {31'd0, done}, 32'd0);
    endtask

    // Reference: scan the bank in index order, first MA hits win
    task automatic compute_expected(input int ln);
        int x, y, off;
        bit h;
        exp_n   = 0;
        exp_ovf = 1'b0;
        exp_bg  = int'(bank[0][8:0]);
        for (int k = 1; k <= 20; k++) begin
            x   = int'(bank[k][9:0]);
            y   = int'(bank[k][19:10]);
            off = int'(bank[k][29:20]);
            h = (off != 0) && (y <= ln) && (ln < y + 20);
`ifdef SPRITE_SCAN_CLIP_EN
            if (x >= 640 || y >= 480) h = 1'b0;
`endif
            if (h) begin
                if (exp_n < MA) begin
                    exp_x[exp_n]   = x;
                    exp_row[exp_n] = ln - y;
                    exp_off[exp_n] = off;
                    exp_n++;
                end else begin
                    exp_ovf = 1'b1;
                end
            end
        end
    endtask

    task automatic compare_all(input string tag);
        logic [3:0] ev;
        ev = 4'((1 << exp_n) - 1);
        check({tag, " valid"}, {28'd0, act_valid}, {28'd0, ev});
        check({tag, " ovf"}, {31'd0, overflow}, {31'd0, exp_ovf});
        check({tag, " bg"}, {23'd0, bg_color}, exp_bg);
        for (int i = 0; i < MA; i++) begin
            if (i < exp_n) begin
                check($sformatf("%s x%0d", tag, i), {22'd0, act_x[10*i +: 10]}, exp_x[i]);
                check($sformatf("%s row%0d", tag, i), {27'd0, act_row[5*i +: 5]}, exp_row[i]);
                check($sformatf("%s off%0d", tag, i), {22'd0, act_offset[10*i +: 10]}, exp_off[i]);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy"}, {31'd0, busy}, 32'd0);
        check({tag, " done"}, {31'd0, done}, 32'd0);
        check({tag, " ovf"}, {31'd0, overflow}, 32'd0);
        check({tag, " valid"}, {28'd0, act_valid}, 32'd0);
        check({tag, " rf_n_reg"}, {27'd0, rf_n_reg}, 32'd0);
        check({tag, " rf_written"}, {31'd0, rf_written}, 32'd0);
        check({tag, " bg"}, {23'd0, bg_color}, 32'd0);
        check({tag, " act_x"}, {24'd0, act_x}, 32'd0);
        check({tag, " act_row"}, {12'd0, act_row}, 32'd0);
        check({tag, " act_off"}, {24'd0, act_offset}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  done_seen;
        int  lat;
        int  ln;

        // Single-sprite vectors: {bg, line, reg, x, y, off, valid, x0, row0, off0}
        vec[0] = '{'h1A5, 50, 0, 0, 0, 0, 4'b0000, 0, 0, 0};
        vec[1] = '{'h011, 50, 3, 100, 40, 7, 4'b0001, 100, 10, 7};
        vec[2] = '{'h022, 49, 5, 0, 30, 1, 4'b0001, 0, 19, 1};
        vec[3] = '{'h033, 50, 5, 0, 30, 1, 4'b0000, 0, 0, 0};
        vec[4] = '{'h044, 50, 6, 5, 50, 9, 4'b0001, 5, 0, 9};
`ifdef SPRITE_SCAN_CLIP_EN
        vec[5] = '{'h055, 15, 1, 700, 10, 3, 4'b0000, 0, 0, 0};
        vec[7] = '{'h077, 1020, 8, 12, 1015, 2, 4'b0000, 0, 0, 0};
`else
        vec[5] = '{'h055, 15, 1, 700, 10, 3, 4'b0001, 700, 5, 3};
        vec[7] = '{'h077, 1020, 8, 12, 1015, 2, 4'b0001, 12, 5, 2};
`endif
        vec[6] = '{'h066, 0, 20, 639, 0, 1023, 4'b0001, 639, 0, 1023};
        vec[8] = '{'h088, 40, 9, 1, 20, 0, 4'b0000, 0, 0, 0};
        vec[9] = '{'h099, 20, 10, 3, 21, 5, 4'b0000, 0, 0, 0};

        start        = 1'b0;
        line         = '0;
        reset_n      = 1'b0;
        rf_read_data = '0;
        clear_bank(0);
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        for (int v = 0; v < 10; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            clear_bank(vec[v].bg);
            if (vec[v].k != 0) bank[vec[v].k] = mkword(vec[v].x, vec[v].y, vec[v].off);
            run_scan(vec[v].ln, tag);
            check({tag, " valid"}, {28'd0, act_valid}, {28'd0, vec[v].ev});
            check({tag, " ovf"}, {31'd0, overflow}, 32'd0);
            check({tag, " bg"}, {23'd0, bg_color}, vec[v].bg);
            if (vec[v].ev[0]) begin
                check({tag, " x0"}, {22'd0, act_x[9:0]}, vec[v].ex);
                check({tag, " row0"}, {27'd0, act_row[4:0]}, vec[v].er);
                check({tag, " off0"}, {22'd0, act_offset[9:0]}, vec[v].eo);
            end
        end

        // Six sprites cover line 100: first four by index fill the slots
        clear_bank('h0F0);
        bank[2]  = mkword(20, 85, 2);
        bank[4]  = mkword(40, 86, 4);
        bank[7]  = mkword(70, 87, 7);
        bank[9]  = mkword(90, 88, 9);
        bank[11] = mkword(110, 89, 11);
        bank[15] = mkword(150, 90, 15);
        run_scan(100, "six");
        check("six valid", {28'd0, act_valid}, 32'hF);
        check("six ovf", {31'd0, overflow}, 32'd1);
        check("six x", {8'd0, act_x[39:30], act_x[29:20], act_x[9:0]}, {8'd0, 10'd90, 10'd70, 10'd20});
        check("six x1", {22'd0, act_x[19:10]}, 32'd40);
        check("six row", {12'd0, act_row}, {12'd0, 5'd12, 5'd13, 5'd14, 5'd15});
        check("six off", {22'd0, act_offset[39:30]}, 32'd9);
        check("six off0", {22'd0, act_offset[9:0]}, 32'd2);

        // Second start at E0+5 is ignored: one done at 23 and no more
        clear_bank('h123);
        bank[3] = mkword(33, 60, 6);
        @(negedge clk);
        start = 1'b1;
        line  = 10'd65;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = -1;
        done_seen = 0;
        for (int c = 1; c <= 60; c++) begin
            if (c == 5) begin
                @(negedge clk);
                start = 1'b1;
                line  = 10'd200;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                done_seen++;
                if (lat < 0) lat = c;
            end
        end
        check("restart latency", lat, 23);
        check("restart done count", done_seen, 1);
        check("restart row0", {27'd0, act_row[4:0]}, 32'd5);

        // Reset at E0+10 aborts the scan and clears the committed list
        clear_bank('h1FF);
        bank[1] = mkword(1, 95, 1);
        @(negedge clk);
        start = 1'b1;
        line  = 10'd100;
        @(posedge clk);
        #1;
        start = 1'b0;
        done_seen = 0;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        check("abort pre busy", {31'd0, busy}, 32'd1);
        check("abort pre valid", {28'd0, act_valid}, 32'h1);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("abort");
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        check("abort no done", done_seen, 0);

        // Start coinciding with reset is dropped
        @(negedge clk);
        reset_n = 1'b0;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("start during reset", {31'd0, busy}, 32'd0);

        // Randomized scans against the reference model
        for (int it = 0; it < 25; it++) begin
            ln = int'($urandom_range(0, 1023));
            clear_bank(int'($urandom_range(0, 511)));
            for (int k = 1; k <= 20; k++) begin
                int x, y, off;
                x   = int'($urandom_range(0, 1023));
                y   = ln - int'($urandom_range(0, 24));
                if (y < 0) y = 0;
                if ($urandom_range(0, 3) == 0) y = int'($urandom_range(0, 1023));
                off = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 1023));
                bank[k] = mkword(x, y, off);
            end
            compute_expected(ln);
            run_scan(ln, $sformatf("rnd%0d", it));
            compare_all($sformatf("rnd%0d", it));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
